// File: rtl/mem_access_unit.sv
// ME-stage memory access unit: registered data-bus master with byte-lane
// alignment, store strobes, load sign/zero extension, misalign and timeout detection.
module mem_access_unit #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned STRB_W         = XLEN / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_rena,
  input  logic              ex_mem_wena,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic              ex_flush,
  input  logic              wb_allow_in,
  output logic              mem_valid,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [1:0]        mem_size,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [1:0]        mem_resp,
  output logic [XLEN-1:0]   me_rdata,
  output logic              me_done,
  output logic              me_misalign,
  output logic              me_bus_err,
  output logic              stall_req
);

  localparam int unsigned OFF_W = $clog2(STRB_W);
  localparam int unsigned CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_nx;

  logic            req_wr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [CW-1:0]   cnt;
  logic            drop;

  logic              start;
  logic              misaligned;
  logic [OFF_W-1:0]  ex_off;
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W-1:0]  req_off;
  logic              in_req;
  logic              timeout_hit;
  logic              finish;
  logic              discard;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ext_mask;
  logic              sign_bit;
  logic [XLEN-1:0]   load_ext;
  logic [STRB_W-1:0] lane_mask;

  assign start   = ex_valid & (ex_mem_rena | ex_mem_wena);
  assign ex_off  = ex_addr[OFF_W-1:0];
  assign req_off = req_addr[OFF_W-1:0];
  assign in_req  = (state == REQ);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !mem_ready;
  assign finish      = in_req & (mem_ready | timeout_hit);
  assign discard     = drop | ex_flush;

  always_comb begin
    align_mask = OFF_W'((32'd1 << ex_mem_size) - 32'd1);
    misaligned = (|(ex_off & align_mask)) || ((XLEN == 32) && (ex_mem_size == 2'd3));
  end

  // Sign bit is the top bit of the size mask, which keeps the extraction width-generic.
  always_comb begin
    shifted  = mem_rdata >> {req_off, 3'b000};
    ext_mask = (XLEN'(1) << (32'd8 << req_size)) - XLEN'(1);
    sign_bit = |(shifted & ext_mask & ~(ext_mask >> 1));
    load_ext = (shifted & ext_mask) | ((sign_bit & ~req_unsigned) ? ~ext_mask : '0);
  end

  always_comb begin
    lane_mask = (STRB_W'(1) << (32'd1 << req_size)) - STRB_W'(1);
  end

  assign mem_valid = in_req;
  assign mem_req   = in_req & req_wr;
  assign mem_addr  = in_req ? {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata = (in_req & req_wr) ? (req_wdata << {req_off, 3'b000}) : '0;
  assign mem_wstrb = (in_req & req_wr) ? (lane_mask << req_off) : '0;
  assign mem_size  = in_req ? req_size : '0;
  assign me_done   = (state == DONE);

  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_nx  = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (finish) state_nx = discard ? IDLE : DONE;
      end
      DONE: begin
        stall_req = ~wb_allow_in;
        if (wb_allow_in | ex_flush) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_wr       <= 1'b0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      cnt          <= '0;
      drop         <= 1'b0;
      me_rdata     <= '0;
      me_misalign  <= 1'b0;
      me_bus_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            req_wr       <= ex_mem_wena;
            req_size     <= ex_mem_size;
            req_unsigned <= ex_mem_unsigned;
            req_addr     <= ex_addr;
            req_wdata    <= ex_wdata;
            cnt          <= '0;
            drop         <= 1'b0;
            me_rdata     <= '0;
            me_bus_err   <= 1'b0;
            me_misalign  <= misaligned;
          end
        end
        REQ: begin
          if (ex_flush) drop <= 1'b1;
          if (finish) begin
            cnt <= '0;
            if (!discard) begin
              me_rdata   <= (mem_ready && !req_wr) ? load_ext : '0;
              me_bus_err <= mem_ready ? (mem_resp != 2'd0) : 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (wb_allow_in | ex_flush) begin
            me_rdata    <= '0;
            me_misalign <= 1'b0;
            me_bus_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=64, 4-cycle bus timeout).
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_rena, ex_mem_wena, ex_mem_unsigned, ex_flush, wb_allow_in;
  logic [1:0]  ex_mem_size;
  logic [63:0] ex_addr, ex_wdata;
  logic        mem_valid, mem_req, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic [1:0]  mem_size, mem_resp;
  logic [63:0] me_rdata;
  logic        me_done, me_misalign, me_bus_err, stall_req;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_rena(ex_mem_rena), .ex_mem_wena(ex_mem_wena),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_flush(ex_flush), .wb_allow_in(wb_allow_in),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_size(mem_size), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .me_rdata(me_rdata), .me_done(me_done), .me_misalign(me_misalign),
    .me_bus_err(me_bus_err), .stall_req(stall_req)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a, input logic [63:0] wd);
    ex_valid        = 1'b1;
    ex_mem_rena     = rd;
    ex_mem_wena     = wr;
    ex_mem_size     = sz;
    ex_mem_unsigned = uns;
    ex_addr         = a;
    ex_wdata        = wd;
    #1;
  endtask

  task automatic idle_ex();
    ex_valid    = 1'b0;
    ex_mem_rena = 1'b0;
    ex_mem_wena = 1'b0;
  endtask

  task automatic respond(input logic [63:0] rd, input logic [1:0] rsp);
    mem_ready = 1'b1;
    mem_rdata = rd;
    mem_resp  = rsp;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_resp  = '0;
  endtask

  initial begin
    reset = 1'b1;
    ex_flush = 1'b0; wb_allow_in = 1'b1; mem_ready = 1'b0; mem_rdata = '0; mem_resp = '0;
    ex_mem_size = '0; ex_mem_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
    idle_ex();
    tick(); tick();
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_me_done", {63'd0, me_done}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_me_rdata", me_rdata, 64'd0);
    chk("rst_flags", {62'd0, me_misalign, me_bus_err}, 64'd0);
    reset = 1'b0;
    tick();

    // Aligned LD: issue c0, mem_valid c1, ready c2, done c3
    issue(1, 0, 2'd3, 0, 64'h80000010, '0);
    chk("ld_issue_stall", {63'd0, stall_req}, 64'd1);
    tick(); idle_ex();
    chk("ld_mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("ld_mem_addr", mem_addr, 64'h80000010);
    chk("ld_wstrb", {56'd0, mem_wstrb}, 64'd0);
    chk("ld_mem_req", {63'd0, mem_req}, 64'd0);
    chk("ld_mem_size", {62'd0, mem_size}, 64'd3);
    tick();
    chk("ld_c2_not_done", {63'd0, me_done}, 64'd0);
    respond(64'h1122334455667788, 2'd0);
    chk("ld_done", {63'd0, me_done}, 64'd1);
    chk("ld_rdata", me_rdata, 64'h1122334455667788);
    chk("ld_valid_drop", {63'd0, mem_valid}, 64'd0);
    chk("ld_bus_err", {63'd0, me_bus_err}, 64'd0);
    tick();
    chk("ld_back_idle", {63'd0, me_done}, 64'd0);

    // Signed LB at byte 3
    issue(1, 0, 2'd0, 0, 64'h80000003, '0);
    tick(); idle_ex();
    chk("lb_mem_addr", mem_addr, 64'h80000000);
    respond(64'h0000000080000000, 2'd0);
    chk("lb_signed", me_rdata, 64'hFFFFFFFFFFFFFF80);
    tick();

    // Unsigned LBU at byte 3
    issue(1, 0, 2'd0, 1, 64'h80000003, '0);
    tick(); idle_ex();
    respond(64'h0000000080000000, 2'd0);
    chk("lbu_unsigned", me_rdata, 64'h0000000000000080);
    tick();

    // Signed LH at offset 2 picking 0x8001
    issue(1, 0, 2'd1, 0, 64'h80000002, '0);
    tick(); idle_ex();
    respond(64'h0000000080010000, 2'd0);
    chk("lh_signed", me_rdata, 64'hFFFFFFFFFFFF8001);
    tick();

    // SH at offset 6
    issue(0, 1, 2'd1, 0, 64'h80000006, 64'h000000000000ABCD);
    tick(); idle_ex();
    chk("sh_mem_req", {63'd0, mem_req}, 64'd1);
    chk("sh_wstrb", {56'd0, mem_wstrb}, 64'h00000000000000C0);
    chk("sh_wdata", mem_wdata, 64'hABCD000000000000);
    chk("sh_mem_addr", mem_addr, 64'h80000000);
    respond(64'hFFFFFFFFFFFFFFFF, 2'd0);
    chk("sh_done", {63'd0, me_done}, 64'd1);
    chk("sh_rdata_zero", me_rdata, 64'd0);
    tick();

    // rena and wena both set: store wins
    issue(1, 1, 2'd2, 0, 64'h80000004, 64'h0000000012345678);
    tick(); idle_ex();
    chk("both_mem_req", {63'd0, mem_req}, 64'd1);
    chk("both_wstrb", {56'd0, mem_wstrb}, 64'h00000000000000F0);
    chk("both_wdata", mem_wdata, 64'h1234567800000000);
    respond('0, 2'd0);
    tick();

    // Misaligned LW
    issue(1, 0, 2'd2, 0, 64'h80000002, '0);
    chk("mis_stall", {63'd0, stall_req}, 64'd1);
    tick(); idle_ex();
    chk("mis_no_valid", {63'd0, mem_valid}, 64'd0);
    chk("mis_done", {63'd0, me_done}, 64'd1);
    chk("mis_flag", {63'd0, me_misalign}, 64'd1);
    tick();
    chk("mis_no_valid_after", {63'd0, mem_valid}, 64'd0);
    chk("mis_flag_clear", {63'd0, me_misalign}, 64'd0);

    // Timeout: mem_valid for exactly 4 cycles, then bus error
    issue(1, 0, 2'd3, 0, 64'h80000020, '0);
    tick(); idle_ex();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_valid_%0d", i), {63'd0, mem_valid}, 64'd1);
      tick();
    end
    chk("to_valid_dropped", {63'd0, mem_valid}, 64'd0);
    chk("to_done", {63'd0, me_done}, 64'd1);
    chk("to_bus_err", {63'd0, me_bus_err}, 64'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("to_late_ready", {62'd0, mem_valid, me_done}, 64'd0);

    // Error response
    issue(1, 0, 2'd2, 0, 64'h80000008, '0);
    tick(); idle_ex();
    respond(64'h0, 2'd2);
    chk("resp_err_done", {63'd0, me_done}, 64'd1);
    chk("resp_err_flag", {63'd0, me_bus_err}, 64'd1);
    tick();

    // Flush during REQ: transfer completes, no me_done
    issue(1, 0, 2'd3, 0, 64'h80000030, '0);
    tick(); idle_ex();
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    chk("flush_still_valid", {63'd0, mem_valid}, 64'd1);
    respond(64'h55, 2'd0);
    chk("flush_no_done", {63'd0, me_done}, 64'd0);
    chk("flush_valid_drop", {63'd0, mem_valid}, 64'd0);
    chk("flush_stall", {63'd0, stall_req}, 64'd0);
    tick();
    chk("flush_no_done_later", {63'd0, me_done}, 64'd0);

    // DONE held for 3 cycles while wb_allow_in=0
    issue(1, 0, 2'd3, 0, 64'h80000008, '0);
    tick(); idle_ex();
    wb_allow_in = 1'b0;
    respond(64'hDEADBEEFCAFEF00D, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_done_%0d", i), {63'd0, me_done}, 64'd1);
      chk($sformatf("hold_rdata_%0d", i), me_rdata, 64'hDEADBEEFCAFEF00D);
      chk($sformatf("hold_stall_%0d", i), {63'd0, stall_req}, 64'd1);
      tick();
    end
    wb_allow_in = 1'b1;
    #1;
    chk("hold_release_stall", {63'd0, stall_req}, 64'd0);
    tick();
    chk("hold_released", {63'd0, me_done}, 64'd0);

    // Reset during REQ
    issue(1, 0, 2'd3, 0, 64'h80000040, '0);
    tick(); idle_ex();
    chk("rreq_valid", {63'd0, mem_valid}, 64'd1);
    reset = 1'b1;
    tick();
    chk("rreq_valid_drop", {63'd0, mem_valid}, 64'd0);
    chk("rreq_stall", {63'd0, stall_req}, 64'd0);
    chk("rreq_done", {63'd0, me_done}, 64'd0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
